reg_bank: RTL and testbench

- Wishbone classic slave that implements the test register window (REGMEM) addressed by the test-program processor.
- Holds writable 16-bit registers that drive the device-under-test inputs.
- Exposes read-only 16-bit registers that sample device-under-test outputs through a two-flop synchronizer, so the processor's WAIT command can poll them.
- Sits directly downstream of the processor on its Wishbone bus, beside the program-memory slave.

---
 rtl/reg_bank_pkg.sv | 16 +
 rtl/reg_bank_sync.sv | 21 ++
 rtl/reg_bank.sv | 86 ++++++++
 tb/tb_reg_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants for the test-program processor, its register window and benches.
package reg_bank_pkg;
  localparam int unsigned REGMEM_START = 'h00000;
  localparam int unsigned REGMEM_SIZE  = 'h10000;
  localparam int unsigned REGMEM_END   = REGMEM_START + REGMEM_SIZE;  // exclusive
  localparam int          REG_W        = 16;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_WRITE = 4'h1,
    OP_WAIT  = 4'h2,
    OP_DELAY = 4'h3,
    OP_JUMP  = 4'h4,
    OP_HALT  = 4'hF
  } opcode_e;
endpackage

// File: rtl/reg_bank_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous DUT signals.
module sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/reg_bank.sv
// Wishbone classic slave for the REGMEM test window: writable DUT drive
// registers plus synchronized read-only DUT sample registers.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 24,
  parameter int unsigned BASE          = REGMEM_START,
  parameter int unsigned WINDOW        = REGMEM_SIZE,
  parameter int          NUM_OUT       = 8,
  parameter int          NUM_IN        = 8,
  parameter logic [15:0] OUT_RESET     = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] wbAdrI,
  input  logic [15:0]              wbDatI,
  output logic [15:0]              wbDatO,
  input  logic                     wbCycI,
  input  logic                     wbStbI,
  input  logic                     wbWeI,
  output logic                     wbAckO,
  output logic [16*NUM_OUT-1:0]    dutOut,
  output logic [NUM_OUT-1:0]       dutOutStb,
  input  logic [16*NUM_IN-1:0]     dutIn
);
  // One extra bit so BASE+WINDOW at the top of the address space cannot wrap.
  localparam logic [ADDRESS_WIDTH:0] LO = (ADDRESS_WIDTH+1)'(BASE);
  localparam logic [ADDRESS_WIDTH:0] HI = (ADDRESS_WIDTH+1)'(BASE + WINDOW);

  logic [ADDRESS_WIDTH:0]     adrExt;
  logic                       hit, accept;
  logic [15:0]                offset, rdData;
  logic [NUM_OUT-1:0][15:0]   outReg;
  logic [NUM_IN-1:0][15:0]    inSync;
  logic [NUM_OUT-1:0]         wrSel;

  assign adrExt = {1'b0, wbAdrI};
  assign hit    = wbCycI & wbStbI & (adrExt >= LO) & (adrExt < HI);
  // Blocking on the registered ack makes a held strobe alternate request/ack.
  assign accept = hit & ~wbAckO;
  assign offset = 16'(wbAdrI) - 16'(BASE);
  assign dutOut = outReg;

  sync2 #(.W(16*NUM_IN)) uSync (
    .clk  (clk),
    .rst_n(rst),
    .d    (dutIn),
    .q    (inSync)
  );

  always_comb begin
    wrSel = '0;
    for (int k = 0; k < NUM_OUT; k++)
      wrSel[k] = accept & wbWeI & (offset == 16'(k));
  end

  always_comb begin
    rdData = '0;
    for (int k = 0; k < NUM_OUT; k++)
      if (offset == 16'(k)) rdData = outReg[k];
    for (int j = 0; j < NUM_IN; j++)
      if (offset == 16'(NUM_OUT + j)) rdData = inSync[j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outReg    <= {NUM_OUT{OUT_RESET}};
      dutOutStb <= '0;
    end else begin
      dutOutStb <= wrSel;
      for (int k = 0; k < NUM_OUT; k++)
        if (wrSel[k]) outReg[k] <= wbDatI;
    end
  end

  // Writes to inputs or unmapped offsets are still acked so the master never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbAckO <= 1'b0;
      wbDatO <= '0;
    end else begin
      wbAckO <= accept;
      if (accept && !wbWeI) wbDatO <= rdData;
    end
  end
endmodule

// File: tb/tb_reg_bank.sv
// Randomised bench for reg_bank against a register-map model kept in arrays.
module tb_reg_bank;
  import reg_bank_pkg::*;

  localparam int          AW     = 24;
  localparam int          NO     = 8;
  localparam int          NI     = 8;
  localparam int unsigned BASE   = REGMEM_START;
  localparam int unsigned WINDOW = REGMEM_SIZE;
  localparam logic [15:0] ORST   = 16'hC0DE;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [AW-1:0]     wbAdrI = '0;
  logic [15:0]       wbDatI = '0;
  logic [15:0]       wbDatO;
  logic              wbCycI = 1'b0, wbStbI = 1'b0, wbWeI = 1'b0;
  logic              wbAckO;
  logic [16*NO-1:0]  dutOut;
  logic [NO-1:0]     dutOutStb;
  logic [16*NI-1:0]  dutIn = '0;

  int nCmp = 0;
  int nErr = 0;

  logic [15:0] mOut[NO];
  logic [15:0] mIn[NI];

  reg_bank #(
    .ADDRESS_WIDTH(AW), .BASE(BASE), .WINDOW(WINDOW),
    .NUM_OUT(NO), .NUM_IN(NI), .OUT_RESET(ORST)
  ) dut (
    .clk(clk), .rst(rst),
    .wbAdrI(wbAdrI), .wbDatI(wbDatI), .wbDatO(wbDatO),
    .wbCycI(wbCycI), .wbStbI(wbStbI), .wbWeI(wbWeI), .wbAckO(wbAckO),
    .dutOut(dutOut), .dutOutStb(dutOutStb), .dutIn(dutIn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [16*NO-1:0] packOut();
    logic [16*NO-1:0] v;
    for (int k = 0; k < NO; k++) v[16*k +: 16] = mOut[k];
    return v;
  endfunction

  function automatic logic [15:0] expRead(input int off);
    if (off < NO) return mOut[off];
    if (off < NO + NI) return mIn[off - NO];
    return 16'h0000;
  endfunction

  // Bus driver: presents one request from a negedge, waits up to 10 cycles
  // for ack, releases the bus and spends one idle cycle.
  task automatic xfer(input logic [AW-1:0] adr, input logic we, input logic [15:0] dat,
                      output int lat, output logic [15:0] rd, output logic [NO-1:0] stbAck,
                      output logic [16*NO-1:0] outAck, output logic ackAfter,
                      output logic [NO-1:0] stbAfter);
    lat = -1; rd = '0; stbAck = '0; outAck = '0;
    wbAdrI = adr; wbWeI = we; wbDatI = dat; wbCycI = 1'b1; wbStbI = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (wbAckO) begin
        lat = c; rd = wbDatO; stbAck = dutOutStb; outAck = dutOut;
        break;
      end
    end
    wbCycI = 1'b0; wbStbI = 1'b0; wbWeI = 1'b0;
    @(negedge clk);
    ackAfter = wbAckO; stbAfter = dutOutStb;
  endtask

  task automatic randIn();
    for (int j = 0; j < NI; j++) begin
      dutIn[16*j +: 16] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    randIn();
    if (dutIn[15:0] == 16'h1234) dutIn[15:0] = 16'h4321;
    repeat (3) @(negedge clk);
    nCmp++; if (wbAckO !== 1'b0) begin nErr++; $display("FAIL reset_ack: got %b want 0", wbAckO); end
    nCmp++; if (wbDatO !== 16'h0) begin nErr++; $display("FAIL reset_dat: got %h want 0000", wbDatO); end
    nCmp++; if (dutOut !== {NO{ORST}}) begin nErr++; $display("FAIL reset_out: got %h want %h", dutOut, {NO{ORST}}); end
    nCmp++; if (dutOutStb !== '0) begin nErr++; $display("FAIL reset_stb: got %b want 0", dutOutStb); end
    for (int k = 0; k < NO; k++) mOut[k] = ORST;
    for (int j = 0; j < NI; j++) mIn[j] = dutIn[16*j +: 16];
    rst = 1'b1;
    // First read after release still sees the cleared second stage.
    begin
      int lat; logic [15:0] rd; logic [NO-1:0] sa, sf; logic [16*NO-1:0] oa; logic af;
      xfer(AW'(BASE + NO), 1'b0, '0, lat, rd, sa, oa, af, sf);
      nCmp++; if (lat != 1 || rd !== 16'h0) begin nErr++; $display("FAIL reset_sync: lat %0d data %h want lat 1 data 0000", lat, rd); end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic [NO-1:0] sa, sf; logic [16*NO-1:0] oa; logic af;
    xfer(AW'(BASE + 2), 1'b1, 16'hA5C3, lat, rd, sa, oa, af, sf);
    mOut[2] = 16'hA5C3;
    nCmp++; if (lat != 1) begin nErr++; $display("FAIL wr_lat: got %0d want 1", lat); end
    nCmp++; if (oa[47:32] !== 16'hA5C3) begin nErr++; $display("FAIL wr_out: got %h want a5c3", oa[47:32]); end
    nCmp++; if (sa !== 8'b00000100) begin nErr++; $display("FAIL wr_stb: got %b want 00000100", sa); end
    nCmp++; if (af !== 1'b0 || sf !== '0) begin nErr++; $display("FAIL wr_after: ack %b stb %b want 0 0", af, sf); end
    xfer(AW'(BASE + 2), 1'b0, '0, lat, rd, sa, oa, af, sf);
    nCmp++; if (lat != 1 || rd !== 16'hA5C3) begin nErr++; $display("FAIL rd_back: lat %0d data %h want 1 a5c3", lat, rd); end
  endtask

  task automatic test_input();
    int lat; logic [15:0] rd; logic [NO-1:0] sa, sf; logic [16*NO-1:0] oa; logic af;
    dutIn[15:0] = 16'h1234;
    // Accepted on the very next edge: second stage still holds the old word.
    xfer(AW'(BASE + NO), 1'b0, '0, lat, rd, sa, oa, af, sf);
    nCmp++; if (rd !== mIn[0]) begin nErr++; $display("FAIL in_early: got %h want %h", rd, mIn[0]); end
    mIn[0] = 16'h1234;
    @(negedge clk);
    xfer(AW'(BASE + NO), 1'b0, '0, lat, rd, sa, oa, af, sf);
    nCmp++; if (lat != 1 || rd !== 16'h1234) begin nErr++; $display("FAIL in_read: lat %0d data %h want 1 1234", lat, rd); end
    xfer(AW'(BASE + NO), 1'b1, 16'hFFFF, lat, rd, sa, oa, af, sf);
    nCmp++; if (lat != 1 || sa !== '0 || oa !== packOut()) begin nErr++; $display("FAIL in_write: lat %0d stb %b out %h want 1 0 %h", lat, sa, oa, packOut()); end
    xfer(AW'(BASE + NO), 1'b0, '0, lat, rd, sa, oa, af, sf);
    nCmp++; if (rd !== 16'h1234) begin nErr++; $display("FAIL in_ro: got %h want 1234", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [15:0] rd, prev; logic [NO-1:0] sa, sf; logic [16*NO-1:0] oa; logic af;
    prev = wbDatO;
    xfer(AW'(BASE + WINDOW), 1'b0, '0, lat, rd, sa, oa, af, sf);
    nCmp++; if (lat != -1) begin nErr++; $display("FAIL oow_ack: acked after %0d cycles, want none", lat); end
    nCmp++; if (wbDatO !== prev) begin nErr++; $display("FAIL oow_dat: got %h want %h", wbDatO, prev); end
    xfer(AW'(BASE + WINDOW), 1'b1, 16'h7777, lat, rd, sa, oa, af, sf);
    nCmp++; if (lat != -1 || dutOut !== packOut()) begin nErr++; $display("FAIL oow_wr: lat %0d out %h want -1 %h", lat, dutOut, packOut()); end
    xfer(AW'(BASE + 'h100), 1'b0, '0, lat, rd, sa, oa, af, sf);
    nCmp++; if (lat != 1 || rd !== 16'h0) begin nErr++; $display("FAIL unmapped_rd: lat %0d data %h want 1 0000", lat, rd); end
    xfer(AW'(BASE + WINDOW - 1), 1'b1, 16'h5555, lat, rd, sa, oa, af, sf);
    nCmp++; if (lat != 1 || sa !== '0 || oa !== packOut()) begin nErr++; $display("FAIL top_wr: lat %0d stb %b out %h want 1 0 %h", lat, sa, oa, packOut()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d[4];
    int idx = 0, acks = 0;
    for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
    wbAdrI = AW'(BASE); wbDatI = d[0]; wbWeI = 1'b1; wbCycI = 1'b1; wbStbI = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      nCmp++; if (wbAckO !== 1'(i % 2)) begin nErr++; $display("FAIL b2b_ack cycle %0d: got %b want %b", i, wbAckO, 1'(i % 2)); end
      if (wbAckO && idx < 4) begin
        acks++;
        mOut[idx] = d[idx];
        nCmp++; if (dutOutStb !== NO'(1 << idx) || dutOut[16*idx +: 16] !== d[idx]) begin
          nErr++; $display("FAIL b2b_wr %0d: stb %b data %h want %b %h", idx, dutOutStb, dutOut[16*idx +: 16], NO'(1 << idx), d[idx]);
        end
        idx++;
        if (idx < 4) begin wbAdrI = AW'(BASE + idx); wbDatI = d[idx]; end
        else begin wbCycI = 1'b0; wbStbI = 1'b0; wbWeI = 1'b0; end
      end
    end
    nCmp++; if (acks != 4) begin nErr++; $display("FAIL b2b_count: got %0d want 4", acks); end
    nCmp++; if (dutOut !== packOut()) begin nErr++; $display("FAIL b2b_regs: got %h want %h", dutOut, packOut()); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] rd; logic [NO-1:0] sa, sf; logic [16*NO-1:0] oa; logic af;
    for (int n = 0; n < 60; n++) begin
      int off; logic we; logic [15:0] dat;
      if ($urandom_range(0, 7) == 0) begin
        randIn();
        repeat (2) @(negedge clk);
        for (int j = 0; j < NI; j++) mIn[j] = dutIn[16*j +: 16];
      end
      off = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NO + NI, WINDOW - 1))
                                         : int'($urandom_range(0, NO + NI + 1));
      we  = 1'($urandom);
      dat = 16'($urandom);
      xfer(AW'(BASE + off), we, dat, lat, rd, sa, oa, af, sf);
      if (we) begin
        if (off < NO) mOut[off] = dat;
        nCmp++; if (lat != 1 || sa !== ((off < NO) ? NO'(1 << off) : NO'(0)) || oa !== packOut()) begin
          nErr++; $display("FAIL rnd_wr off %0d: lat %0d stb %b out %h want 1 %b %h", off, lat, sa, oa,
                           (off < NO) ? NO'(1 << off) : NO'(0), packOut());
        end
      end else begin
        nCmp++; if (lat != 1 || rd !== expRead(off)) begin
          nErr++; $display("FAIL rnd_rd off %0d: lat %0d data %h want 1 %h", off, lat, rd, expRead(off));
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    // Reset lands while the write is presented, before the accepting edge.
    wbAdrI = AW'(BASE + 5); wbDatI = 16'h1357; wbWeI = 1'b1; wbCycI = 1'b1; wbStbI = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    wbCycI = 1'b0; wbStbI = 1'b0; wbWeI = 1'b0;
    for (int k = 0; k < NO; k++) mOut[k] = ORST;
    nCmp++; if (wbAckO !== 1'b0 || dutOutStb !== '0) begin nErr++; $display("FAIL rst_mid_ack: ack %b stb %b want 0 0", wbAckO, dutOutStb); end
    nCmp++; if (dutOut[16*5 +: 16] !== ORST) begin nErr++; $display("FAIL rst_mid_reg: got %h want %h", dutOut[16*5 +: 16], ORST); end
    rst = 1'b1;
    @(negedge clk);
    nCmp++; if (wbAckO !== 1'b0 || dutOut !== packOut()) begin nErr++; $display("FAIL rst_mid_after: ack %b out %h want 0 %h", wbAckO, dutOut, packOut()); end
    // Reset arriving in the ack cycle clears ack, data and the landed write at once.
    wbAdrI = AW'(BASE + 3); wbDatI = 16'h2468; wbWeI = 1'b1; wbCycI = 1'b1; wbStbI = 1'b1;
    @(negedge clk);
    nCmp++; if (wbAckO !== 1'b1 || dutOut[16*3 +: 16] !== 16'h2468) begin nErr++; $display("FAIL rst_ack_pre: ack %b reg %h want 1 2468", wbAckO, dutOut[16*3 +: 16]); end
    rst = 1'b0; wbCycI = 1'b0; wbStbI = 1'b0; wbWeI = 1'b0;
    #1;
    nCmp++; if (wbAckO !== 1'b0 || dutOutStb !== '0 || wbDatO !== 16'h0 || dutOut[16*3 +: 16] !== ORST) begin
      nErr++; $display("FAIL rst_async: ack %b stb %b dat %h reg %h want 0 0 0000 %h", wbAckO, dutOutStb, wbDatO, dutOut[16*3 +: 16], ORST);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_input();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
